// File: rtl/seq_pkg.sv
// Shared encodings for the load/store/add/sub datapath sequencer.
package seq_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    localparam logic SINAL_ADD = 1'b0;
    localparam logic SINAL_SUB = 1'b1;
    localparam logic MUX_IMM   = 1'b0;
    localparam logic MUX_REG   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WRITE_REG,
        ST_WRITE_MEM,
        ST_RETIRE
    } seq_state_t;

    function automatic logic sinal_for(input logic [1:0] op);
        return (op == OP_SUB) ? SINAL_SUB : SINAL_ADD;
    endfunction

    function automatic logic mux_for(input logic [1:0] op);
        return (op == OP_ADD || op == OP_SUB) ? MUX_REG : MUX_IMM;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// 4-bit loadable down-counter timing the operand settle window.
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       count_en,
    output logic       zero
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (count_en && cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/datapath_sequencer.sv
// Multicycle control FSM for the register/adder/memory datapath.
// Build option SEQ_PERF_COUNT_EN adds a live retired-instruction counter.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        opcode,
    input  logic [DATA_W-1:0] ra_in,
    input  logic [DATA_W-1:0] rb_in,
    input  logic [DATA_W-1:0] rw_in,
    input  logic [DATA_W-1:0] imm_in,
    output logic [DATA_W-1:0] Ra,
    output logic [DATA_W-1:0] Rb,
    output logic [DATA_W-1:0] Rw,
    output logic [DATA_W-1:0] C,
    output logic              sinal,
    output logic              sinalMux,
    output logic              weReg,
    output logic              weMem,
    output logic              done,
    output logic [CNT_W-1:0]  instr_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] ra_q, ra_d, rb_q, rb_d, rw_q, rw_d, c_q, c_d;
    logic              sinal_q, sinal_d, mux_q, mux_d;
    logic              we_reg_q, we_reg_d, we_mem_q, we_mem_d;
    logic              done_q, done_d, ready_q, ready_d;
    logic              is_store_q, is_store_d;
    logic              tmr_load, tmr_en, tmr_zero;

    settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (4'(SETTLE_CYCLES - 1)),
        .count_en (tmr_en),
        .zero     (tmr_zero)
    );

    // Strobes and ready are computed from the next state so every output is a flop.
    always_comb begin
        state_d    = state_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        rw_d       = rw_q;
        c_d        = c_q;
        sinal_d    = sinal_q;
        mux_d      = mux_q;
        is_store_d = is_store_q;
        we_reg_d   = 1'b0;
        we_mem_d   = 1'b0;
        done_d     = 1'b0;
        ready_d    = 1'b0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (instr_valid && ready_q) begin
                    ra_d       = ra_in;
                    rb_d       = rb_in;
                    rw_d       = rw_in;
                    c_d        = imm_in;
                    sinal_d    = sinal_for(opcode);
                    mux_d      = mux_for(opcode);
                    is_store_d = (opcode == OP_STORE);
                    tmr_load   = 1'b1;
                    ready_d    = 1'b0;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    if (is_store_q) begin
                        state_d  = ST_WRITE_MEM;
                        we_mem_d = 1'b1;
                    end else begin
                        state_d  = ST_WRITE_REG;
                        we_reg_d = 1'b1;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WRITE_REG, ST_WRITE_MEM: begin
                state_d = ST_RETIRE;
                done_d  = 1'b1;
            end
            ST_RETIRE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ra_q       <= '0;
            rb_q       <= '0;
            rw_q       <= '0;
            c_q        <= '0;
            sinal_q    <= 1'b0;
            mux_q      <= 1'b0;
            is_store_q <= 1'b0;
            we_reg_q   <= 1'b0;
            we_mem_q   <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            rw_q       <= rw_d;
            c_q        <= c_d;
            sinal_q    <= sinal_d;
            mux_q      <= mux_d;
            is_store_q <= is_store_d;
            we_reg_q   <= we_reg_d;
            we_mem_q   <= we_mem_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

`ifdef SEQ_PERF_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts in step with done so the new value is visible alongside the pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (done_d) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = '0;
`endif

    assign instr_ready = ready_q;
    assign Ra          = ra_q;
    assign Rb          = rb_q;
    assign Rw          = rw_q;
    assign C           = c_q;
    assign sinal       = sinal_q;
    assign sinalMux    = mux_q;
    assign weReg       = we_reg_q;
    assign weMem       = we_mem_q;
    assign done        = done_q;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Control unit that drives the load/store/add/sub datapath: register bank, adder, memory, Mux1 and Mux2.
- Accepts one instruction at a time over a valid/ready handshake.
- Sequences `Ra`/`Rb`/`Rw`/`C`/`sinal`/`sinalMux` and issues one-cycle `weReg`/`weMem` strobes at the correct moment.
- Replaces hand-timed control stimulus with a multicycle FSM.

Parameters:
- `DATA_W`, 64, width of register addresses and the immediate `C`.
- `SETTLE_CYCLES`, 2, cycles operands are held before any write strobe; legal range 1..15.
- `CNT_W`, 32, width of the completed-instruction counter (optional feature only).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction fields valid.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `opcode`  in  2  00 LOAD, 01 STORE, 10 ADD, 11 SUB.
- `ra_in`, `rb_in`, `rw_in`  in  DATA_W each  register addresses.
- `imm_in`  in  DATA_W  signed immediate (address offset).
- `Ra`, `Rb`, `Rw`  out  DATA_W each  register bank addresses.
- `C`  out  DATA_W  signed immediate to Mux1.
- `sinal`  out  1  adder control: 0 add, 1 subtract.
- `sinalMux`  out  1  0 selects `C` and memory data; 1 selects `Rb` and adder result.
- `weReg`  out  1  register bank write enable.
- `weMem`  out  1  memory write enable.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `instr_count`  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: async, active-high. While `rst`=1:
  - state = IDLE.
  - `Ra`, `Rb`, `Rw`, `C`, `sinal`, `sinalMux`, `weReg`, `weMem`, `done`, `instr_count` all = 0.
  - `instr_ready` = 0; it rises in the first cycle after reset release.
  - Reset mid-instruction aborts it immediately; no strobe may complete.
- All outputs are registered.
- States: IDLE, SETTLE, WRITE_REG, WRITE_MEM, RETIRE.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`&&`instr_ready`, capture all fields into the outputs in the same edge:
    - `Ra`=`ra_in`, `Rb`=`rb_in`, `Rw`=`rw_in`, `C`=`imm_in`.
    - LOAD: `sinalMux`=0, `sinal`=0.
    - STORE: `sinalMux`=0, `sinal`=0.
    - ADD: `sinalMux`=1, `sinal`=0.
    - SUB: `sinalMux`=1, `sinal`=1.
  - Go to SETTLE.
- SETTLE:
  - `instr_ready`=0; a down-counter loads `SETTLE_CYCLES`-1 on entry.
  - Leaves when the counter reaches 0, so exactly `SETTLE_CYCLES` cycles are spent here.
  - Next state: STORE goes to WRITE_MEM; all other opcodes go to WRITE_REG.
- WRITE_REG: `weReg`=1 for exactly one cycle, then RETIRE.
- WRITE_MEM: `weMem`=1 for exactly one cycle, then RETIRE.
- RETIRE:
  - `done`=1 for one cycle; `instr_count` increments (wraps at 2^CNT_W-1 to 0).
  - Go to IDLE.
- `Ra`, `Rb`, `Rw`, `C`, `sinal`, `sinalMux` hold stable from capture until the next capture. They are not cleared in RETIRE.
- `weReg` and `weMem` are never both 1 and are never 1 outside their write states.
- `instr_valid` while `instr_ready`=0 is ignored; there is no queuing, and the source must hold until accepted.
- Latency from accept to `done`: `SETTLE_CYCLES`+2 cycles. Throughput: one instruction per `SETTLE_CYCLES`+3 cycles.
- Back-to-back: `instr_valid` held high through RETIRE is accepted on the first IDLE cycle.
- `SETTLE_CYCLES` outside 1..15 is a compile-time error (elaboration check).

Optional Feature:
- Macro: `SEQ_PERF_COUNT_EN`.
- Defined: `instr_count` is a live CNT_W counter as described; reset to 0, increments on each `done`, wraps.
- Undefined: no counter register is built; `instr_count` is tied to 0.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package `seq_pkg` holds:
  - opcode encoding constants `OP_LOAD`, `OP_STORE`, `OP_ADD`, `OP_SUB`;
  - state typedef `seq_state_t`;
  - adder and mux control constants `SINAL_ADD`/`SINAL_SUB`, `MUX_IMM`/`MUX_REG`.
- One sub-module, `settle_timer`:
  - 4-bit loadable down-counter with `load`, `count_en`, `zero` outputs;
  - asynchronous `rst`.
- The FSM and output registers stay in `datapath_sequencer`.

Test Plan:
- Reset mid-SETTLE: assert `rst` 1 cycle after accepting ADD → all outputs 0 asynchronously, no `weReg` pulse, `instr_ready`=1 one cycle after release.
- LOAD `ra`=0, `imm`=1, `rw`=2, `SETTLE_CYCLES`=2 → `sinalMux`=0, `C`=1, `Rw`=2; `weReg` high exactly at cycle 3 after accept; `done` at cycle 4; `weMem` never high.
- STORE `ra`=5, `rb`=6, `imm`=0 → `sinalMux`=0, `Ra`=5, `Rb`=6; `weMem` one-cycle pulse at cycle 3; `weReg` stays 0.
- ADD `ra`=2, `rb`=1, `rw`=3, then SUB `ra`=3, `rb`=1, `rw`=4 with `instr_valid` held → `sinal` 0 then 1, `sinalMux`=1; second accept on the cycle after first `done`; two `weReg` pulses 5 cycles apart.
- `instr_valid` pulsed during SETTLE with different fields → ignored; `Ra`/`Rb`/`Rw` unchanged; `instr_ready`=0 throughout.
- With `SEQ_PERF_COUNT_EN` and `CNT_W`=2: retire 5 instructions → `instr_count` sequence 1, 2, 3, 0, 1. Without the macro → `instr_count` stays 0.
